btn_debounce_pulse: RTL

Front-end stage for the LED timer FSM. It conditions a raw, asynchronous, bouncing push-button into a clean one-cycle `start` pulse and a debounced level.
- Two-flop synchronizer, then a 4-state debounce FSM with a settle counter.
- `pulse` drives the LED FSM's `start` input directly.

---
 rtl/fsm_pkg.sv | 15 +
 rtl/sync_2ff.sv | 25 ++
 rtl/btn_debounce_pulse.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
// Shared definitions for the button front-end and the LED timer FSM:
// state encoding and default counter widths.
package fsm_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } state_t;

  localparam int DEBLEN_DEF = 20;
  localparam int REPLEN_DEF = 24;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit,
// synchronous active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Button conditioner: synchronizer, 4-state debounce FSM, one-cycle press pulse.
// Optional auto-repeat while held is enabled by defining BTN_REPEAT_EN.
module btn_debounce_pulse
  import fsm_pkg::*;
#(
  parameter int DEBLEN = DEBLEN_DEF,
  parameter int REPLEN = REPLEN_DEF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       btn_in,
  output logic       pulse,
  output logic       level,
  output logic [3:0] debug
);

  logic              btn_s;
  state_t            state;
  state_t            state_next;
  logic [DEBLEN-1:0] cnt;
  logic [DEBLEN-1:0] cnt_next;
  logic              pulse_next;
  logic              level_next;
  logic [3:0]        debug_next;

`ifdef BTN_REPEAT_EN
  logic [REPLEN-1:0] rep_cnt;
  logic [REPLEN-1:0] rep_next;
`else
  logic unused_replen;
  assign unused_replen = (REPLEN == 0);
`endif

  sync_2ff u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (btn_in),
    .q     (btn_s)
  );

  // State register; pulse, level and debug are registered on the same edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
      debug <= '0;
`ifdef BTN_REPEAT_EN
      rep_cnt <= '0;
`endif
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      pulse <= pulse_next;
      level <= level_next;
      debug <= debug_next;
`ifdef BTN_REPEAT_EN
      rep_cnt <= rep_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pulse_next = 1'b0;
    case (state)
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == '1) begin
          state_next = PRESSED;
          cnt_next   = '0;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt == '1) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        // IDLE, and any unexpected encoding behaves as IDLE
        state_next = btn_s ? PRESS_WAIT : IDLE;
        cnt_next   = '0;
      end
    endcase

`ifdef BTN_REPEAT_EN
    // Repeat counter only runs while the FSM stays in PRESSED.
    rep_next = '0;
    if (state == PRESSED && state_next == PRESSED) begin
      rep_next = rep_cnt + 1'b1;
      if (rep_cnt == '1)
        pulse_next = 1'b1;
    end
`endif
  end

  always_comb begin
    level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
    debug_next = {state, btn_s, pulse_next};
  end

endmodule
